axis_write_seq: RTL and testbench



---
 rtl/axis_write_seq.sv | 190 +++++++++++++++++++
 tb/tb_axis_write_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_write_seq.sv
// Descriptor FIFO plus cfg-bus sequencer (ID, start address, length) for one axis_write.
// Define AXIS_WRITE_SEQ_STATS_EN to add the done_count and stray_beat outputs.
module axis_write_seq #(
    parameter int unsigned CFG_ID      = 1,
    parameter int unsigned CFG_ADDR    = 23,
    parameter int unsigned CFG_DATA    = 24,
    parameter int unsigned CFG_AWIDTH  = 5,
    parameter int unsigned CFG_DWIDTH  = 32,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned DESC_AWIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_DWIDTH-1:0] desc_addr,
    input  logic [CFG_DWIDTH-1:0] desc_len,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic                  cfg_valid,
    input  logic                  mon_valid,
    input  logic                  mon_ready,
    output logic                  busy,
    output logic                  done
`ifdef AXIS_WRITE_SEQ_STATS_EN
    ,
    output logic [CFG_DWIDTH-1:0] done_count,
    output logic                  stray_beat
`endif
);
    localparam int unsigned DEPTH = 1 << DESC_AWIDTH;
    localparam logic [CFG_AWIDTH-1:0] ID_ADDR   = CFG_AWIDTH'(CFG_ADDR);
    localparam logic [CFG_AWIDTH-1:0] DATA_ADDR = CFG_AWIDTH'(CFG_DATA);
    localparam logic [CFG_DWIDTH-1:0] ID_WORD   = CFG_DWIDTH'(CFG_ID);
    localparam logic [31:0]           GAP_LAST  = 32'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StId, StG1, StAddr, StG2, StLen, StRun} state_e;

    state_e                state_q, state_d;
    logic [DESC_AWIDTH:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CFG_DWIDTH-1:0] mem_addr_q [DEPTH];
    logic [CFG_DWIDTH-1:0] mem_len_q  [DEPTH];
    logic [CFG_DWIDTH-1:0] addr_q, addr_d, len_q, len_d, rem_q, rem_d, rem_dec;
    logic [CFG_DWIDTH-1:0] rd_addr, rd_len;
    logic [31:0]           gap_q, gap_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic [CFG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CFG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                  done_q, done_d;
    logic                  full, empty, push, pop, beat;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[DESC_AWIDTH] != rd_ptr_q[DESC_AWIDTH]) &&
                        (wr_ptr_q[DESC_AWIDTH-1:0] == rd_ptr_q[DESC_AWIDTH-1:0]);
    assign push       = desc_valid && !full;
    assign wr_ptr_d   = wr_ptr_q + {{DESC_AWIDTH{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{DESC_AWIDTH{1'b0}}, pop};
    assign rd_addr    = mem_addr_q[rd_ptr_q[DESC_AWIDTH-1:0]];
    assign rd_len     = mem_len_q[rd_ptr_q[DESC_AWIDTH-1:0]];

    assign desc_ready = !full;
    assign cfg_valid  = cfg_valid_q;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_data   = cfg_data_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle) || !empty;

    always_comb begin
        beat        = mon_valid && mon_ready;
        rem_dec     = (beat && rem_q != '0) ? rem_q - CFG_DWIDTH'(1) : rem_q;
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        gap_d       = gap_q;
        rem_d       = (state_q == StIdle) ? rem_q : rem_dec;
        pop         = 1'b0;
        done_d      = 1'b0;
        cfg_valid_d = 1'b0;
        cfg_addr_d  = '0;
        cfg_data_d  = '0;
        unique case (state_q)
            StIdle: begin
                // No pop while done is high, so the next ID word trails completion by 2 cycles.
                if (!empty && !done_q) begin
                    pop    = 1'b1;
                    addr_d = rd_addr;
                    len_d  = rd_len;
                    rem_d  = rd_len;
                    if (rd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = StId;
                        cfg_valid_d = 1'b1;
                        cfg_addr_d  = ID_ADDR;
                        cfg_data_d  = ID_WORD;
                    end
                end
            end
            StId, StG1: begin
                if ((state_q == StId && GAP_CYCLES == 0) || (state_q == StG1 && gap_q == '0)) begin
                    state_d     = StAddr;
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = DATA_ADDR;
                    cfg_data_d  = addr_q;
                end else begin
                    state_d = StG1;
                    gap_d   = (state_q == StId) ? GAP_LAST : gap_q - 32'd1;
                end
            end
            StAddr, StG2: begin
                if ((state_q == StAddr && GAP_CYCLES == 0) || (state_q == StG2 && gap_q == '0)) begin
                    state_d     = StLen;
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = DATA_ADDR;
                    cfg_data_d  = len_q;
                end else begin
                    state_d = StG2;
                    gap_d   = (state_q == StAddr) ? GAP_LAST : gap_q - 32'd1;
                end
            end
            StLen: state_d = StRun;
            StRun: begin
                if (rem_dec == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            gap_q       <= '0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q[DESC_AWIDTH-1:0]] <= desc_addr;
            mem_len_q[wr_ptr_q[DESC_AWIDTH-1:0]]  <= desc_len;
        end
    end

`ifdef AXIS_WRITE_SEQ_STATS_EN
    logic [CFG_DWIDTH-1:0] done_count_q, done_count_d;
    logic                  stray_q, stray_d;

    always_comb begin
        done_count_d = done_d ? done_count_q + CFG_DWIDTH'(1) : done_count_q;
        stray_d      = stray_q ||
                       (beat && (state_q == StIdle || (state_q == StRun && rem_q == '0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_count_q <= '0;
            stray_q      <= 1'b0;
        end else begin
            done_count_q <= done_count_d;
            stray_q      <= stray_d;
        end
    end

    assign done_count = done_count_q;
    assign stray_beat = stray_q;
`endif
endmodule

// File: tb/tb_axis_write_seq.sv
// Bench for axis_write_seq: two instances (GAP_CYCLES 0 and 2) share stimulus and are checked
// every cycle against a timeline model, plus literal checks on the directed scenarios.
module tb_axis_write_seq;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int GAP0 = 0;
    localparam int GAP1 = 2;

    logic                clk, rst;
    logic [DW-1:0]       desc_addr, desc_len;
    logic                desc_valid, mon_valid, mon_ready;
    logic [1:0]          desc_ready_w, cfg_valid_w, busy_w, done_w;
    logic [1:0][AW-1:0]  cfg_addr_w;
    logic [1:0][DW-1:0]  cfg_data_w;

    int total = 0;
    int bad   = 0;

    axis_write_seq #(.GAP_CYCLES(GAP0)) u_dut0 (
        .clk(clk), .rst(rst), .desc_addr(desc_addr), .desc_len(desc_len),
        .desc_valid(desc_valid), .desc_ready(desc_ready_w[0]), .cfg_addr(cfg_addr_w[0]),
        .cfg_data(cfg_data_w[0]), .cfg_valid(cfg_valid_w[0]), .mon_valid(mon_valid),
        .mon_ready(mon_ready), .busy(busy_w[0]), .done(done_w[0])
    );

    axis_write_seq #(.GAP_CYCLES(GAP1)) u_dut2 (
        .clk(clk), .rst(rst), .desc_addr(desc_addr), .desc_len(desc_len),
        .desc_valid(desc_valid), .desc_ready(desc_ready_w[1]), .cfg_addr(cfg_addr_w[1]),
        .cfg_data(cfg_data_w[1]), .cfg_valid(cfg_valid_w[1]), .mon_valid(mon_valid),
        .mon_ready(mon_ready), .busy(busy_w[1]), .done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Timeline model: k counts cycles since the pop; cfg words sit at fixed offsets from it.
    logic [63:0]   m_buf [2][64];
    int            m_head [2], m_tail [2], m_k [2];
    bit            m_active [2], m_done [2];
    logic [DW-1:0] m_addr [2], m_len [2], m_rem [2];
    bit            started = 1'b0;
    int            done_cnt0 = 0;

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP0 : GAP1;
    endfunction

    task automatic model_check(input int i);
        int            g;
        bit            ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        g  = gap_of(i);
        ev = 1'b0;
        ea = '0;
        ed = '0;
        if (m_active[i]) begin
            if (m_k[i] == 1) begin
                ev = 1'b1; ea = AW'(23); ed = DW'(1);
            end else if (m_k[i] == 2 + g) begin
                ev = 1'b1; ea = AW'(24); ed = m_addr[i];
            end else if (m_k[i] == 3 + 2 * g) begin
                ev = 1'b1; ea = AW'(24); ed = m_len[i];
            end
        end
        chk("cfg_valid", i, 64'(cfg_valid_w[i]), 64'(ev));
        if (ev) begin
            chk("cfg_addr", i, 64'(cfg_addr_w[i]), 64'(ea));
            chk("cfg_data", i, 64'(cfg_data_w[i]), 64'(ed));
        end
        chk("done", i, 64'(done_w[i]), 64'(m_done[i]));
        chk("busy", i, 64'(busy_w[i]), 64'(m_active[i] || (m_tail[i] != m_head[i])));
        chk("desc_ready", i, 64'(desc_ready_w[i]), 64'((m_tail[i] - m_head[i]) < 4));
    endtask

    task automatic model_step(input int i);
        int g;
        bit beat, push, nd;
        g    = gap_of(i);
        beat = mon_valid && mon_ready;
        push = desc_valid && ((m_tail[i] - m_head[i]) < 4);
        nd   = 1'b0;
        if (m_active[i]) begin
            if (beat && m_rem[i] != 0) m_rem[i] = m_rem[i] - 1;
            if (m_k[i] >= 4 + 2 * g && m_rem[i] == 0) begin
                m_active[i] = 1'b0;
                nd = 1'b1;
            end else begin
                m_k[i]++;
            end
        end else if (m_tail[i] != m_head[i] && !m_done[i]) begin
            {m_addr[i], m_len[i]} = m_buf[i][m_head[i] % 64];
            m_head[i]++;
            m_rem[i] = m_len[i];
            if (m_len[i] == 0) begin
                nd = 1'b1;
            end else begin
                m_active[i] = 1'b1;
                m_k[i] = 1;
            end
        end
        if (push) begin
            m_buf[i][m_tail[i] % 64] = {desc_addr, desc_len};
            m_tail[i]++;
        end
        m_done[i] = nd;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int i = 0; i < 2; i++) model_check(i);
                if (done_w[0]) done_cnt0++;
            end
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    m_head[i] = 0; m_tail[i] = 0; m_k[i] = 0; m_rem[i] = '0;
                    m_active[i] = 1'b0; m_done[i] = 1'b0;
                end
                started = 1'b1;
            end else if (started) begin
                for (int i = 0; i < 2; i++) model_step(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input bit b);
        mon_valid = b;
        mon_ready = b;
    endtask

    task automatic lit_word(input string name, input int i, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        chk({name, "_valid"}, i, 64'(cfg_valid_w[i]), 64'(1));
        chk({name, "_addr"}, i, 64'(cfg_addr_w[i]), 64'(a));
        chk({name, "_data"}, i, 64'(cfg_data_w[i]), 64'(d));
    endtask

    task automatic lit_gap(input string name, input int i);
        chk(name, i, 64'(cfg_valid_w[i]), 64'(0));
    endtask

    task automatic push_one(input logic [DW-1:0] a, input logic [DW-1:0] l);
        desc_addr  = a;
        desc_len   = l;
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        beats(1'b1);
        while ((busy_w[0] || busy_w[1]) && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", 0, 64'(n < 300), 64'(1));
        beats(1'b0);
        repeat (3) tick();
    endtask

    initial begin
        int n, m, d0;
        bit accepted;
        rst = 1'b1;
        desc_valid = 1'b0;
        desc_addr = '0;
        desc_len = '0;
        beats(1'b0);
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cfg_valid", i, 64'(cfg_valid_w[i]), 64'(0));
            chk("rst_cfg_addr", i, 64'(cfg_addr_w[i]), 64'(0));
            chk("rst_cfg_data", i, 64'(cfg_data_w[i]), 64'(0));
            chk("rst_done", i, 64'(done_w[i]), 64'(0));
            chk("rst_busy", i, 64'(busy_w[i]), 64'(0));
            chk("rst_ready", i, 64'(desc_ready_w[i]), 64'(1));
        end

        // Basic sequence, no gap: ID/ADDR/LEN at T+2..T+4, four beats, done one cycle later.
        push_one(32'h1000, 32'd4);
        tick();
        lit_word("t1_id", 0, AW'(23), DW'(1));
        lit_word("t1_id", 1, AW'(23), DW'(1));
        tick();
        lit_word("t1_addr", 0, AW'(24), 32'h1000);
        lit_gap("t1_gap", 1);
        tick();
        lit_word("t1_len", 0, AW'(24), 32'd4);
        tick();
        lit_gap("t1_run", 0);
        beats(1'b1);
        repeat (3) tick();
        chk("t1_done_early", 0, 64'(done_w[0]), 64'(0));
        tick();
        beats(1'b0);
        chk("t1_done", 0, 64'(done_w[0]), 64'(1));
        chk("t1_busy_low", 0, 64'(busy_w[0]), 64'(0));
        tick();
        chk("t1_done_pulse", 0, 64'(done_w[0]), 64'(0));
        wait_idle();

        // Two gap cycles between words on the GAP_CYCLES=2 instance.
        push_one(32'h2000, 32'd1);
        tick();
        lit_word("t2_id", 1, AW'(23), DW'(1));
        tick(); lit_gap("t2_gap_a", 1);
        tick(); lit_gap("t2_gap_b", 1);
        tick(); lit_word("t2_addr", 1, AW'(24), 32'h2000);
        tick(); lit_gap("t2_gap_c", 1);
        tick(); lit_gap("t2_gap_d", 1);
        tick(); lit_word("t2_len", 1, AW'(24), 32'd1);
        wait_idle();

        // Back-to-back pushes with no beats: one in flight plus a full FIFO of four.
        d0 = done_cnt0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            desc_valid = desc_ready_w[0] && desc_ready_w[1];
            desc_addr  = 32'h3000 + 32'(n) * 32'h100;
            desc_len   = 32'd2;
            tick();
            if (desc_valid) n++;
        end
        desc_valid = 1'b0;
        chk("t3_accepted", 0, 64'(n), 64'(5));
        chk("t3_ready_low", 0, 64'(desc_ready_w[0]), 64'(0));
        m = 0;
        accepted = 1'b0;
        beats(1'b1);
        while (!accepted && m < 100) begin
            desc_valid = desc_ready_w[0] && desc_ready_w[1];
            desc_addr  = 32'h3000 + 32'(n) * 32'h100;
            tick();
            if (desc_valid) accepted = 1'b1;
            m++;
        end
        desc_valid = 1'b0;
        chk("t3_sixth_accepted", 0, 64'(accepted), 64'(1));
        wait_idle();
        chk("t3_done_count", 0, 64'(done_cnt0 - d0), 64'(6));

        // Zero-length descriptor completes without cfg writes; the next one sequences normally.
        desc_valid = 1'b1;
        desc_addr  = 32'h4000;
        desc_len   = 32'd0;
        tick();
        desc_addr  = 32'h4100;
        desc_len   = 32'd2;
        tick();
        desc_valid = 1'b0;
        chk("t4_done_len0", 0, 64'(done_w[0]), 64'(1));
        lit_gap("t4_no_cfg_a", 0);
        tick();
        chk("t4_done_pulse", 0, 64'(done_w[0]), 64'(0));
        lit_gap("t4_no_cfg_b", 0);
        tick(); lit_word("t4_id", 0, AW'(23), DW'(1));
        tick(); lit_word("t4_addr", 0, AW'(24), 32'h4100);
        tick(); lit_word("t4_len", 0, AW'(24), 32'd2);
        wait_idle();

        // Two of three beats land during ADDR/LEN; one beat in RUN finishes it.
        push_one(32'h5000, 32'd3);
        tick();
        tick();
        beats(1'b1);
        lit_word("t5_addr", 0, AW'(24), 32'h5000);
        tick();
        tick();
        beats(1'b0);
        chk("t5_no_done_run", 0, 64'(done_w[0]), 64'(0));
        tick();
        beats(1'b1);
        chk("t5_no_done_beat", 0, 64'(done_w[0]), 64'(0));
        tick();
        beats(1'b0);
        chk("t5_done", 0, 64'(done_w[0]), 64'(1));
        wait_idle();

        // Reset in RUN with a second descriptor queued: everything is abandoned.
        push_one(32'h6000, 32'd5);
        desc_addr  = 32'h6100;
        desc_len   = 32'd3;
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
        repeat (3) tick();
        chk("t6_busy_in_run", 0, 64'(busy_w[0]), 64'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t6_cfg_valid", i, 64'(cfg_valid_w[i]), 64'(0));
            chk("t6_busy", i, 64'(busy_w[i]), 64'(0));
            chk("t6_done", i, 64'(done_w[i]), 64'(0));
            chk("t6_ready", i, 64'(desc_ready_w[i]), 64'(1));
        end
        beats(1'b1);
        repeat (8) begin
            tick();
            chk("t6_no_done", 0, 64'(done_w[0]), 64'(0));
            chk("t6_no_done", 1, 64'(done_w[1]), 64'(0));
        end
        beats(1'b0);
        tick();

        // Random traffic, beats and occasional resets, checked by the model each cycle.
        for (int c = 0; c < 4000; c++) begin
            desc_valid = ($urandom_range(2) == 0) && desc_ready_w[0] && desc_ready_w[1];
            desc_addr  = $urandom;
            desc_len   = $urandom_range(6);
            mon_valid  = $urandom_range(3) != 0;
            mon_ready  = $urandom_range(2) != 0;
            rst        = $urandom_range(599) == 0;
            tick();
        end
        rst = 1'b0;
        desc_valid = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
